// File: rtl/scan_chain_controller.sv
`default_nettype none
// scan_chain_controller: host-side shift controller and CHAIN_LEN-bit shadow register for a serial scan chain.
// Optional macro SCAN_CAPTURE_EN enables the recirculating CAPTURE op. Rev 1.0
module scan_chain_controller #(
  parameter int CHAIN_LEN = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  output logic                 cmd_ready,
  output logic                 done,
  output logic                 cmd_err,
  input  logic                 shadow_we,
  input  logic [CHAIN_LEN-1:0] shadow_wdata,
  output logic [CHAIN_LEN-1:0] shadow_rdata,
  output logic                 scan_enable,
  output logic                 scan_in,
  input  logic                 scan_out
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [1:0] OP_SWAP  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b10;
`ifdef SCAN_CAPTURE_EN
  localparam logic [1:0] OP_CAPTURE = 2'b01;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 err_q, err_d;
  logic                 sen_q, sen_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0] shifted;
  logic                 op_legal;

  generate
    if (CHAIN_LEN == 1) begin : g_shift_one
      assign shifted = scan_out;
    end else begin : g_shift_many
      assign shifted = {shadow_q[CHAIN_LEN-2:0], scan_out};
    end
  endgenerate

  always_comb begin
    op_legal = 1'b0;
    case (cmd_op)
      OP_SWAP, OP_CLEAR: op_legal = 1'b1;
`ifdef SCAN_CAPTURE_EN
      OP_CAPTURE:        op_legal = 1'b1;
`endif
      default:           op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        // A same-cycle host write lands first, so the command shifts the new data.
        if (shadow_we) shadow_d = shadow_wdata;
        if (cmd_valid) begin
          op_d    = cmd_op;
          cnt_d   = CW'(CHAIN_LEN);
          err_d   = ~op_legal;
          state_d = op_legal ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        shadow_d = shifted;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    sen_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_SWAP;
      err_q    <= 1'b0;
      sen_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      err_q    <= err_d;
      sen_q    <= sen_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    scan_in = 1'b0;
    if (sen_q) begin
      case (op_q)
        OP_SWAP:    scan_in = shadow_q[CHAIN_LEN-1];
`ifdef SCAN_CAPTURE_EN
        OP_CAPTURE: scan_in = scan_out;
`endif
        default:    scan_in = 1'b0;
      endcase
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign cmd_err      = (state_q == ST_DONE) & err_q;
  assign scan_enable  = sen_q;
  assign shadow_rdata = shadow_q;

endmodule
`default_nettype wire
